// File: rtl/riscv_pkg.sv
// Shared RISC-V core types: ID/EX control bundle and the bubble control word.
package riscv_pkg;

  typedef enum logic {
    NOWR = 1'b0,
    WR   = 1'b1
  } regwr_e;

  typedef struct packed {
    regwr_e     reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [3:0] alu_op;
    logic       alu_src_a;
    logic       alu_src_b;
    logic       branch;
    logic       jump;
  } id_ex_ctrl_t;

  // Control word of a bubble: writes nothing, touches no memory, never redirects.
  localparam id_ex_ctrl_t NOP_CTRL = '{
    reg_write: NOWR,
    mem_read:  1'b0,
    mem_write: 1'b0,
    alu_op:    4'd0,
    alu_src_a: 1'b0,
    alu_src_b: 1'b0,
    branch:    1'b0,
    jump:      1'b0
  };

endpackage

// File: rtl/lu_detect.sv
// Load-use hazard detector: ID reads a register that the load in EX has yet to produce.
module lu_detect #(
  parameter int REG_AW = 5
) (
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  output logic              lu
);

  logic rs1_hit, rs2_hit;

  assign rs1_hit = id_use_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit = id_use_rs2 && (id_rs2 == ex_rd);
  // x0 is hardwired, so a load targeting it never blocks a reader.
  assign lu = id_valid && ex_valid && ex_mem_read && (ex_rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubbling, flush and memory-freeze handling.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  id_ex_ctrl_t       id_ctrl,
  input  logic              ex_flush,
  input  logic              mem_stall,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [REG_AW-1:0] ex_rd,
  output logic [XLEN-1:0]   ex_rs1_data,
  output logic [XLEN-1:0]   ex_rs2_data,
  output logic [XLEN-1:0]   ex_imm,
  output id_ex_ctrl_t       ex_ctrl,
  output logic              pc_write_en,
  output logic              if_id_write_en,
  output logic              load_use_stall,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    id_ex_ctrl_t       ctrl;
  } stage_t;

  stage_t           stage_q, stage_d, bubble, incoming;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lu;

  lu_detect #(.REG_AW(REG_AW)) u_lu (
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_valid    (stage_q.valid),
    .ex_mem_read (stage_q.ctrl.mem_read),
    .ex_rd       (stage_q.rd),
    .lu          (lu)
  );

  always_comb begin
    bubble      = '0;
    bubble.ctrl = NOP_CTRL;

    incoming = '{valid: id_valid, pc: id_pc, rs1: id_rs1, rs2: id_rs2, rd: id_rd,
                 rs1_data: id_rs1_data, rs2_data: id_rs2_data, imm: id_imm, ctrl: id_ctrl};
    // Empty slots must look like bubbles to the forwarding unit.
    if (!id_valid) begin
      incoming.rd   = '0;
      incoming.ctrl = NOP_CTRL;
    end

    stage_d        = stage_q;
    cnt_d          = cnt_q;
    pc_write_en    = 1'b1;
    if_id_write_en = 1'b1;
    load_use_stall = 1'b0;

    if (mem_stall) begin
      pc_write_en    = 1'b0;
      if_id_write_en = 1'b0;
    end else if (ex_flush) begin
      stage_d = bubble;
    end else if (lu) begin
      stage_d        = bubble;
      pc_write_en    = 1'b0;
      if_id_write_en = 1'b0;
      load_use_stall = 1'b1;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end else begin
      stage_d = incoming;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q      <= '0;
      stage_q.ctrl <= NOP_CTRL;
      cnt_q        <= '0;
    end else begin
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ex_valid    = stage_q.valid;
  assign ex_pc       = stage_q.pc;
  assign ex_rs1      = stage_q.rs1;
  assign ex_rs2      = stage_q.rs2;
  assign ex_rd       = stage_q.rd;
  assign ex_rs1_data = stage_q.rs1_data;
  assign ex_rs2_data = stage_q.rs2_data;
  assign ex_imm      = stage_q.imm;
  assign ex_ctrl     = stage_q.ctrl;
  assign bubble_cnt  = cnt_q;

endmodule
